// File: rtl/icon_xfer_engine_if.sv
// Handshake bundle for one interconnect routing lane: request queue input,
// producer read port and the two consumer write channels.
interface icon_xfer_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_dst_i;
  logic              req_ready_o;

  logic [ADDR_W-1:0] src_raddr_o;
  logic              src_rvalid_o;
  logic [DATA_W-1:0] src_rdata_i;
  logic              src_rsuccess_i;

  logic [ADDR_W-1:0] dst_w0_addr_o;
  logic [ADDR_W-1:0] dst_w1_addr_o;
  logic [DATA_W-1:0] dst_w0_data_o;
  logic [DATA_W-1:0] dst_w1_data_o;
  logic              dst_w0_valid_o;
  logic              dst_w1_valid_o;
  logic              dst_w0_success_i;
  logic              dst_w1_success_i;

  // Engine side.
  modport master (
    input  req_valid_i, req_addr_i, req_dst_i,
    output req_ready_o,
    output src_raddr_o, src_rvalid_o,
    input  src_rdata_i, src_rsuccess_i,
    output dst_w0_addr_o, dst_w1_addr_o, dst_w0_data_o, dst_w1_data_o,
    output dst_w0_valid_o, dst_w1_valid_o,
    input  dst_w0_success_i, dst_w1_success_i
  );

  // Requester / producer / consumer side.
  modport slave (
    output req_valid_i, req_addr_i, req_dst_i,
    input  req_ready_o,
    input  src_raddr_o, src_rvalid_o,
    output src_rdata_i, src_rsuccess_i,
    input  dst_w0_addr_o, dst_w1_addr_o, dst_w0_data_o, dst_w1_data_o,
    input  dst_w0_valid_o, dst_w1_valid_o,
    output dst_w0_success_i, dst_w1_success_i
  );
endinterface

// File: rtl/icon_xfer_engine.sv
// Transfer initiator: queues operand-move requests, reads each operand from the
// producer (with bounded retry) and writes it to the selected consumer channel.
module icon_xfer_engine #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int QDEPTH      = 4,
  parameter int RETRY_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  icon_xfer_engine_if.master   bus,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [7:0]           drop_cnt_o
);
  localparam int PW = (QDEPTH < 2) ? 1 : $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (RETRY_LIMIT < 2) ? 1 : $clog2(RETRY_LIMIT);
  localparam logic [RW-1:0] RETRY_LAST = RW'((RETRY_LIMIT == 0) ? 0 : RETRY_LIMIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_dst_q, cur_dst_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic [RW-1:0]     retry_cnt_q, retry_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  // Each entry stores {dst, addr}.
  logic [ADDR_W:0]   fifo_mem [QDEPTH];
  logic [ADDR_W:0]   head;
  logic              req_ready, push, pop, fifo_empty, wr_success;

  logic              rvalid_c, w0_valid_c, w1_valid_c;
  logic [ADDR_W-1:0] raddr_c, w0_addr_c, w1_addr_c;
  logic [DATA_W-1:0] w0_data_c, w1_data_c;

  assign req_ready  = (count_q != CW'(QDEPTH)) & ~reset;
  assign push       = bus.req_valid_i & req_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign wr_success = cur_dst_q ? bus.dst_w1_success_i : bus.dst_w0_success_i;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.req_dst_i, bus.req_addr_i};
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_dst_d   = cur_dst_q;
    cur_data_d  = cur_data_q;
    retry_cnt_d = retry_cnt_q;
    err_d       = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    pop         = 1'b0;
    rvalid_c    = 1'b0;
    raddr_c     = '0;
    w0_valid_c  = 1'b0;
    w0_addr_c   = '0;
    w0_data_c   = '0;
    w1_valid_c  = 1'b0;
    w1_addr_c   = '0;
    w1_data_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          cur_addr_d  = head[ADDR_W-1:0];
          cur_dst_d   = head[ADDR_W];
          retry_cnt_d = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        rvalid_c = 1'b1;
        raddr_c  = cur_addr_q;
        if (bus.src_rsuccess_i) begin
          cur_data_d = bus.src_rdata_i;
          state_d    = ST_WRITE;
        end else if ((RETRY_LIMIT != 0) && (retry_cnt_q == RETRY_LAST)) begin
          err_d      = 1'b1;
          drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
          state_d    = ST_IDLE;
        end else if (RETRY_LIMIT != 0) begin
          retry_cnt_d = retry_cnt_q + RW'(1);
        end
      end
      ST_WRITE: begin
        // Producer entry is already consumed, so the write is held until accepted.
        if (cur_dst_q) begin
          w1_valid_c = 1'b1;
          w1_addr_c  = cur_addr_q;
          w1_data_c  = cur_data_q;
        end else begin
          w0_valid_c = 1'b1;
          w0_addr_c  = cur_addr_q;
          w0_data_c  = cur_data_q;
        end
        if (wr_success) begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            cur_addr_d  = head[ADDR_W-1:0];
            cur_dst_d   = head[ADDR_W];
            retry_cnt_d = '0;
            state_d     = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    busy_d   = (state_d != ST_IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      cur_dst_q   <= 1'b0;
      cur_data_q  <= '0;
      retry_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cur_dst_q   <= cur_dst_d;
      cur_data_q  <= cur_data_d;
      retry_cnt_q <= retry_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.src_rvalid_o   = rvalid_c;
  assign bus.src_raddr_o    = raddr_c;
  assign bus.dst_w0_valid_o = w0_valid_c;
  assign bus.dst_w0_addr_o  = w0_addr_c;
  assign bus.dst_w0_data_o  = w0_data_c;
  assign bus.dst_w1_valid_o = w1_valid_c;
  assign bus.dst_w1_addr_o  = w1_addr_c;
  assign bus.dst_w1_data_o  = w1_data_c;
  assign busy_o             = busy_q;
  assign err_o              = err_q;
  assign drop_cnt_o         = drop_cnt_q;
endmodule
